// File: rtl/slice_pack_pkg.sv
// slice_pack_pkg: shared widths, op codes, FSM encoding and the pack function
//   A_W/B_W/D_W : operand and result widths
//   OP_*        : pack op codes
//   state_t     : controller FSM state encoding
//   xact_t      : operands captured for one transaction
//   pack()      : builds the packed byte from slices of a and b
package slice_pack_pkg;

    localparam int A_W = 8;
    localparam int B_W = 7;
    localparam int D_W = 8;

    localparam logic [1:0] OP_SWAP_LO = 2'b00;
    localparam logic [1:0] OP_ROT     = 2'b01;
    localparam logic [1:0] OP_MERGE   = 2'b10;
    localparam logic [1:0] OP_SLICE   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CAPT = 2'd1;
    localparam state_t ST_PACK = 2'd2;
    localparam state_t ST_HOLD = 2'd3;

    typedef struct packed {
        logic           src;
        logic [1:0]     op;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } xact_t;

    function automatic logic [D_W-1:0] pack(
        input logic [1:0]     op,
        input logic [A_W-1:0] a,
        input logic [B_W-1:0] b
    );
        pack = (op == OP_SWAP_LO) ? {a[3:0], b[3:0]} :
               (op == OP_ROT)     ? {b[3:0], a[7:4]} :
               (op == OP_MERGE)   ? {b[6:3], a[3:0]} :
                                    {6'b0, a[3:2]};
    endfunction

endpackage

// File: rtl/slice_pack_rr_arb.sv
// slice_pack_rr_arb: 2-way arbiter with last-winner pointer and registered grants
//   clk, rst     : clock, async active-high reset
//   en           : arbitration allowed this cycle
//   req0, req1   : requests
//   gnt0, gnt1   : registered one-cycle grant pulses
//   win          : combinational winner index (meaningful while take=1)
//   take         : a request is accepted this cycle
module slice_pack_rr_arb #(
    parameter bit FAIR = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic win,
    output logic take
);

    logic last_src_q, last_src_d;
    logic gnt0_q, gnt0_d;
    logic gnt1_q, gnt1_d;

    // With a single requester the winner is simply whoever asks (~req0);
    // only a true tie under FAIR consults the pointer.
    always_comb begin
        take       = en & (req0 | req1);
        win        = (FAIR && req0 && req1) ? ~last_src_q : ~req0;
        last_src_d = take ? win : last_src_q;
        gnt0_d     = take & ~win;
        gnt1_d     = take & win;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_src_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            last_src_q <= last_src_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;

endmodule

// File: rtl/slice_pack_arbiter.sv
// slice_pack_arbiter: two requesters sharing one slice/concat pack unit
//   clk, rst           : clock, async active-high reset
//   req*/op*/a*/b*     : per-requester request, op code and operands
//   gnt0, gnt1         : one-cycle pulse when a request is captured
//   out_data, out_src  : packed byte and its requester index
//   out_valid/ready    : output handshake, data held until accepted
//   busy               : FSM not in IDLE
module slice_pack_arbiter
    import slice_pack_pkg::*;
#(
    parameter bit             FAIR       = 1'b1,
    parameter logic [D_W-1:0] RESET_DATA = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [1:0]     op0,
    input  logic [1:0]     op1,
    input  logic [A_W-1:0] a0,
    input  logic [A_W-1:0] a1,
    input  logic [B_W-1:0] b0,
    input  logic [B_W-1:0] b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic [D_W-1:0] out_data,
    output logic           out_src,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);

    state_t         state_q, state_d;
    xact_t          xact_q, xact_d;
    logic [D_W-1:0] out_data_q, out_data_d;
    logic           out_src_q, out_src_d;
    logic           win, take;

    slice_pack_rr_arb #(.FAIR(FAIR)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_IDLE),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .win  (win),
        .take (take)
    );

    // Operands are latched on the same edge the arbiter records its winner,
    // so later input changes cannot leak into the transaction.
    always_comb begin
        state_d = (state_q == ST_IDLE) ? (take ? ST_CAPT : ST_IDLE) :
                  (state_q == ST_CAPT) ? ST_PACK :
                  (state_q == ST_PACK) ? ST_HOLD :
                  (out_ready ? ST_IDLE : ST_HOLD);
        xact_d = take ? {win, win ? op1 : op0, win ? a1 : a0, win ? b1 : b0} : xact_q;
        out_data_d = (state_q == ST_PACK) ? pack(xact_q.op, xact_q.a, xact_q.b) : out_data_q;
        out_src_d  = (state_q == ST_PACK) ? xact_q.src : out_src_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            xact_q     <= '0;
            out_data_q <= RESET_DATA;
            out_src_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xact_q     <= xact_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_slice_pack_arbiter.sv
// tb_slice_pack_arbiter: directed self-checking bench, round-robin and fixed-priority instances
module tb_slice_pack_arbiter;

    logic       clk, rst;
    logic       req0, req1, out_ready;
    logic [1:0] op0, op1;
    logic [7:0] a0, a1;
    logic [6:0] b0, b1;

    logic       gnt0, gnt1, out_src, out_valid, busy;
    logic [7:0] out_data;
    logic       gnt0_f, gnt1_f, out_src_f, out_valid_f, busy_f;
    logic [7:0] out_data_f;

    int n_chk = 0;
    int n_fail = 0;

    slice_pack_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    slice_pack_arbiter #(.FAIR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .gnt0(gnt0_f), .gnt1(gnt1_f),
        .out_data(out_data_f), .out_src(out_src_f), .out_valid(out_valid_f),
        .out_ready(out_ready), .busy(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One uncontended transaction on requester 1 with out_ready high.
    task automatic txn1(input logic [1:0] op, input logic [7:0] a, input logic [6:0] b,
                        input logic [7:0] exp, input string tag);
        req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        step();
        chk({tag, "_gnt1"}, gnt1, 8'd1);
        chk({tag, "_gnt0"}, gnt0, 8'd0);
        req1 = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, out_valid, 8'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_src"}, out_src, 8'd1);
        step();
        chk({tag, "_idle"}, busy, 8'd0);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        a0 = 8'h00; a1 = 8'h00; b0 = 7'h00; b1 = 7'h00; out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt0", gnt0, 8'd0);
            chk("rst_gnt1", gnt1, 8'd0);
            chk("rst_valid", out_valid, 8'd0);
            chk("rst_busy", busy, 8'd0);
            chk("rst_src", out_src, 8'd0);
            chk("rst_data", out_data, 8'h00);
        end
        chk("rst_fp_busy", busy_f, 8'd0);
        chk("rst_fp_data", out_data_f, 8'h00);

        // Both requesting right after release: req0 wins first.
        req0 = 1'b1; req1 = 1'b1; rst = 1'b0;
        step();
        chk("first_gnt0", gnt0, 8'd1);
        chk("first_gnt1", gnt1, 8'd0);
        chk("first_busy", busy, 8'd1);
        chk("first_fp_gnt0", gnt0_f, 8'd1);
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        chk("first_valid", out_valid, 8'd1);
        chk("first_src", out_src, 8'd0);
        chk("first_data", out_data, 8'h00);
        step();
        chk("first_idle", busy, 8'd0);

        // Async reset in HOLD of a req0 op11 transaction.
        req0 = 1'b1; op0 = 2'b11; a0 = 8'hFA; b0 = 7'h00;
        step();
        chk("ar_gnt0", gnt0, 8'd1);
        req0 = 1'b0;
        step();
        step();
        chk("ar_valid", out_valid, 8'd1);
        chk("ar_data", out_data, 8'h02);
        chk("ar_fp_src", out_src_f, 8'd0);
        rst = 1'b1;
        #1;
        chk("ar_valid_drop", out_valid, 8'd0);
        chk("ar_busy_drop", busy, 8'd0);
        chk("ar_data_rst", out_data, 8'h00);
        chk("ar_src_rst", out_src, 8'd0);
        chk("ar_fp_valid_drop", out_valid_f, 8'd0);
        #1;
        rst = 1'b0;

        // Pointer is back at 1: req0 wins the tie; a0 changes in the gnt cycle.
        req0 = 1'b1; req1 = 1'b1; op0 = 2'b00; a0 = 8'h0E; b0 = 7'h7F;
        step();
        chk("single_gnt0", gnt0, 8'd1);
        chk("single_gnt1", gnt1, 8'd0);
        chk("single_valid_n1", out_valid, 8'd0);
        req0 = 1'b0; req1 = 1'b0; a0 = 8'h55;
        step();
        chk("single_valid_n2", out_valid, 8'd0);
        chk("single_busy_n2", busy, 8'd1);
        step();
        chk("single_valid_n3", out_valid, 8'd1);
        chk("single_data", out_data, 8'hEF);
        chk("single_src", out_src, 8'd0);
        step();
        chk("single_idle", busy, 8'd0);
        chk("single_valid_n4", out_valid, 8'd0);
        chk("single_data_kept", out_data, 8'hEF);

        txn1(2'b01, 8'h0E, 7'h7F, 8'hF0, "op01");
        txn1(2'b10, 8'h0E, 7'h7F, 8'hFE, "op10");
        txn1(2'b11, 8'hFA, 7'h7F, 8'h02, "op11");

        // Contention: round-robin alternates, fixed priority always picks req0.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cont_gnt0", gnt0, 8'((i % 2) == 0));
            chk("cont_gnt1", gnt1, 8'((i % 2) == 1));
            chk("cont_fp_gnt0", gnt0_f, 8'd1);
            chk("cont_fp_gnt1", gnt1_f, 8'd0);
            step();
            step();
            chk("cont_valid", out_valid, 8'd1);
            chk("cont_src", out_src, 8'(i % 2));
            step();
        end
        req0 = 1'b0; req1 = 1'b0;

        // Backpressure with req1 pending.
        out_ready = 1'b0;
        req0 = 1'b1; op0 = 2'b00; a0 = 8'h0E; b0 = 7'h7F;
        step();
        chk("bp_gnt0", gnt0, 8'd1);
        req0 = 1'b0; req1 = 1'b1; op1 = 2'b01; a1 = 8'h0E; b1 = 7'h7F;
        step();
        step();
        chk("bp_valid", out_valid, 8'd1);
        chk("bp_data", out_data, 8'hEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", out_valid, 8'd1);
            chk("bp_hold_data", out_data, 8'hEF);
            chk("bp_hold_src", out_src, 8'd0);
            chk("bp_hold_gnt0", gnt0, 8'd0);
            chk("bp_hold_gnt1", gnt1, 8'd0);
            chk("bp_hold_busy", busy, 8'd1);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle", busy, 8'd0);
        chk("bp_idle_gnt1", gnt1, 8'd0);
        step();
        chk("bp_gnt1", gnt1, 8'd1);
        req1 = 1'b0;
        step();
        step();
        chk("bp2_valid", out_valid, 8'd1);
        chk("bp2_data", out_data, 8'hF0);
        chk("bp2_src", out_src, 8'd1);
        step();
        chk("bp2_idle", busy, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_pack_arbiter.md
# slice_pack_arbiter

Two-requester controller that shares one 8-bit slice/concatenation pack unit. Each requester supplies an 8-bit `a` operand, a 7-bit `b` operand and a 2-bit op code. The block arbitrates between requesters, captures the winning operands, builds the packed byte from bit slices of `a` and `b`, and presents it on a valid/ready output. It sits between operand-producing logic and any downstream consumer of packed bytes.

## Interface
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where req0 always wins.
- `RESET_DATA`, default 8'h00: reset and initial value of `out_data`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req0`, `req1`  in  1  request from requester 0 / 1.
- `op0`, `op1`  in  2  pack op code for each requester.
- `a0`, `a1`  in  8  `a` operand for each requester.
- `b0`, `b1`  in  7  `b` operand for each requester.
- `gnt0`, `gnt1`  out  1  registered one-cycle pulse: request captured.
- `out_data`  out  8  packed byte.
- `out_src`  out  1  index of the requester that produced `out_data`.
- `out_valid`  out  1  `out_data` valid; held until accepted.
- `out_ready`  in  1  consumer accepts `out_data` while `out_valid` is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE: arbitrate. Any request moves to CAPT.
  - CAPT: always moves to PACK.
  - PACK: always moves to HOLD.
  - HOLD: stays while `out_ready`=0. Moves to IDLE when `out_ready`=1.
- Arbitration happens only in IDLE. Requests in other states are ignored; they are not queued.
- Pointer `last_src` resets to 1, so req0 wins first.
  - FAIR=1 with both requests: the winner is `~last_src`.
  - FAIR=0: req0 wins whenever it is asserted.
  - `last_src` updates on the IDLE→CAPT edge.
- Operands and op code are latched on the IDLE→CAPT edge. Later changes on the inputs have no effect on the transaction.
- Requester rules:
  - Hold `req`, `op`, `a` and `b` stable until the edge on which it is sampled.
  - Deassert `req` no later than the cycle in which `gnt` is high.
  - A `req` still high when the FSM re-enters IDLE counts as a new request.
- Pack ops. Unused upper bits are zero.
  - 2'b00: {a[3:0], b[3:0]}
  - 2'b01: {b[3:0], a[7:4]}
  - 2'b10: {b[6:3], a[3:0]}
  - 2'b11: {6'b0, a[3:2]}
- `out_data` and `out_src` load on the PACK→HOLD edge. They keep their last value after the handshake and are not cleared.

## Timing
- Reset values: `gnt0`/`gnt1` = 0, `out_valid` = 0, `busy` = 0, `out_src` = 0, `out_data` = RESET_DATA, state = IDLE, `last_src` = 1.
- For a request sampled at the end of cycle N:
  - `gnt` is high in cycle N+1 (CAPT).
  - `out_valid` rises in cycle N+3.
  - If `out_ready` is high in that cycle, `busy` is low in N+4.
- Minimum issue interval is 4 cycles per transaction.
- `out_valid` is a decode of HOLD. While `out_ready`=0, `out_valid`, `out_data` and `out_src` stay stable.
- At most one of `gnt0`/`gnt1` is high in any cycle. `busy` is high in exactly the CAPT, PACK and HOLD cycles.
- Asserting `rst` mid-transaction (any state):
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - The transaction is discarded and `last_src` returns to 1.
  - The first edge after release samples requests normally.

## Structure
- Package `slice_pack_pkg` holds:
  - widths A_W=8, B_W=7, D_W=8;
  - op-code constants OP_SWAP_LO, OP_ROT, OP_MERGE, OP_SLICE;
  - the FSM state type;
  - a pure function `pack(op, a, b)` returning D_W bits.
- Sub-module `slice_pack_rr_arb` is a 2-way arbiter with the pointer register and the FAIR parameter. Its outputs are a registered grant and the winner index.

## Test plan
- Reset: hold `rst` 3 cycles, then drive req0=req1=1. Require all outputs at reset values during reset and `gnt0` first after release. Assert `rst` in HOLD: `out_valid` drops with no clock edge.
- Single request: req0, op=00, a=8'h0E, b=7'h7F. Require `gnt0` in N+1, `out_valid` in N+3, `out_data`=8'hEF, `out_src`=0, with `out_ready` held high.
- Op coverage on requester 1: a=8'h0E, b=7'h7F gives op 01 → 8'hF0 and op 10 → 8'hFE. a=8'hFA with op 11 → 8'h02.
- Contention: req0 and req1 held high for 8 transactions. FAIR=1: grants alternate 0,1,0,1…; FAIR=0: all grants go to 0.
- Backpressure: `out_ready`=0 for 5 cycles with req1 pending. Require `out_data`/`out_src` stable, no `gnt`, and `busy`=1. After `out_ready` rises, req1 is granted on the next IDLE edge.
- Operand change after capture: change a0 in the `gnt0` cycle. Require `out_data` to reflect the originally captured value.
